// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the execute-stage ALU and the ALU control decoder.
//   ALU_WIDTH      default operand/result width
//   ALU_*          4-bit ALU_Control operation codes
//   alu_state_e    FSM state encoding of alu_multicycle
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] ALU_DIV = 4'b0000;  // unsigned divide
  localparam logic [3:0] ALU_MUL = 4'b0001;  // unsigned multiply
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0101;
  localparam logic [3:0] ALU_BNE = 4'b0110;  // A != B
  localparam logic [3:0] ALU_BGT = 4'b0111;  // signed A > B
  localparam logic [3:0] ALU_BLT = 4'b1000;  // signed A < B

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } alu_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: shared iterative engine for unsigned multiply (shift-add)
// and unsigned divide (restoring), one bit per clock, WIDTH steps total.
//   clk, reset   clock, synchronous active-high reset
//   start        load operands; the first step is applied on the load edge
//   is_div       1 = divide, 0 = multiply (captured at start)
//   a, b         multiplier/dividend and multiplicand/divisor
//   done         one-cycle pulse once all WIDTH steps are complete
//   hi, lo       multiply: product high/low; divide: remainder/quotient
// The first step happens on the start edge so that done is visible one cycle
// before the top-level FSM has to register the final result.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] hi_reg, lo_reg, b_reg;
  logic             div_reg, run_reg, done_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [WIDTH-1:0] cur_hi, cur_lo, cur_b;
  logic             cur_div;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;

  // One iteration step, applied either to freshly loaded operands or to the
  // running register pair.
  always_comb begin
    if (start) begin
      cur_hi  = '0;
      cur_lo  = a;
      cur_b   = b;
      cur_div = is_div;
    end else begin
      cur_hi  = hi_reg;
      cur_lo  = lo_reg;
      cur_b   = b_reg;
      cur_div = div_reg;
    end
    mul_sum   = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_b} : '0);
    div_shift = {cur_hi, cur_lo[WIDTH-1]};
    // Partial remainder stays below the divisor, so bit WIDTH of the
    // difference is set exactly when the trial subtraction borrows.
    div_diff  = div_shift - {1'b0, cur_b};
    if (cur_div) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {cur_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {cur_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], cur_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg   <= '0;
      lo_reg   <= '0;
      b_reg    <= '0;
      div_reg  <= 1'b0;
      run_reg  <= 1'b0;
      done_reg <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        hi_reg  <= step_hi;
        lo_reg  <= step_lo;
        b_reg   <= b;
        div_reg <= is_div;
        cnt_reg <= CNT_W'(WIDTH - 1);
        run_reg <= 1'b1;
      end else if (run_reg) begin
        hi_reg  <= step_hi;
        lo_reg  <= step_lo;
        cnt_reg <= cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          run_reg  <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: multi-cycle execute-stage ALU with start/busy/done handshake.
//   clk, reset            clock, synchronous active-high reset
//   start                 launch; honoured only when busy=0 (IDLE or FIN)
//   ALU_Control, A, B     operation code and operands, captured at start
//   Result, Hi            result / quotient, upper product / remainder
//   Zero, Branch_Taken    Result==0, branch condition for bne/bgt/blt
//   busy, done, error     in-flight, one-cycle completion pulse, bad op
// Build option: define ALU_MULDIV_EN to build the iterative multiply/divide
// path; without it codes 0000/0001 are reported as invalid and busy is 0.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALU_Control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Hi,
  output logic             Zero,
  output logic             Branch_Taken,
  output logic             busy,
  output logic             done,
  output logic             error
);

  alu_state_e       state_reg;
  logic [WIDTH-1:0] result_reg, hi_reg;
  logic             zero_reg, branch_reg, done_reg, error_reg;

  logic [WIDTH-1:0] sc_result, sc_hi;
  logic             sc_branch, sc_error;
  logic             accept;

  assign accept = start && (state_reg == ST_IDLE || state_reg == ST_FIN);

  // Single-cycle results; also covers divide-by-zero and invalid codes.
  always_comb begin
    sc_result = '0;
    sc_hi     = '0;
    sc_branch = 1'b0;
    sc_error  = 1'b0;
    case (ALU_Control)
      ALU_SUB: sc_result = A - B;
      ALU_ADD: sc_result = A + B;
      ALU_OR:  sc_result = A | B;
      ALU_AND: sc_result = A & B;
      ALU_BNE: begin
        sc_result = A - B;
        sc_branch = (A != B);
      end
      ALU_BGT: begin
        sc_result = A - B;
        sc_branch = ($signed(A) > $signed(B));
      end
      ALU_BLT: begin
        sc_result = A - B;
        sc_branch = ($signed(A) < $signed(B));
      end
`ifdef ALU_MULDIV_EN
      // Only reaches the output registers when B is zero.
      ALU_DIV: begin
        sc_result = '1;
        sc_hi     = A;
        sc_error  = 1'b1;
      end
      ALU_MUL: sc_error = 1'b0;
`else
      ALU_DIV: sc_error = 1'b1;
      ALU_MUL: sc_error = 1'b1;
`endif
      default: sc_error = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic             busy_reg;
  logic             launch_mul, launch_div, iter_done;
  logic [WIDTH-1:0] iter_hi, iter_lo;

  assign launch_mul = (ALU_Control == ALU_MUL);
  assign launch_div = (ALU_Control == ALU_DIV) && (B != '0);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && (launch_mul || launch_div)),
    .is_div (launch_div),
    .a      (A),
    .b      (B),
    .done   (iter_done),
    .hi     (iter_hi),
    .lo     (iter_lo)
  );

  assign busy = busy_reg;
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      result_reg <= '0;
      hi_reg     <= '0;
      zero_reg   <= 1'b1;
      branch_reg <= 1'b0;
      done_reg   <= 1'b0;
      error_reg  <= 1'b0;
`ifdef ALU_MULDIV_EN
      busy_reg   <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        // FIN accepts a new start so operations can run back to back.
        ST_IDLE, ST_FIN: begin
          state_reg <= ST_IDLE;
          if (accept) begin
`ifdef ALU_MULDIV_EN
            if (launch_mul || launch_div) begin
              state_reg <= launch_div ? ST_DIV : ST_MUL;
              busy_reg  <= 1'b1;
            end else
`endif
            begin
              state_reg  <= ST_FIN;
              result_reg <= sc_result;
              hi_reg     <= sc_hi;
              zero_reg   <= (sc_result == '0);
              branch_reg <= sc_branch;
              error_reg  <= sc_error;
              done_reg   <= 1'b1;
            end
          end
        end
`ifdef ALU_MULDIV_EN
        ST_MUL, ST_DIV: begin
          if (iter_done) begin
            state_reg  <= ST_FIN;
            result_reg <= iter_lo;
            hi_reg     <= iter_hi;
            zero_reg   <= (iter_lo == '0);
            branch_reg <= 1'b0;
            error_reg  <= 1'b0;
            done_reg   <= 1'b1;
            busy_reg   <= 1'b0;
          end
        end
`endif
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign Result       = result_reg;
  assign Hi           = hi_reg;
  assign Zero         = zero_reg;
  assign Branch_Taken = branch_reg;
  assign done         = done_reg;
  assign error        = error_reg;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed scoreboard bench for alu_multicycle.
// Expected results are queued when an operation is launched and compared when
// done pulses. Expectations follow the ALU_MULDIV_EN build option.
module tb_alu_multicycle;

  localparam int W = 32;
`ifdef ALU_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   ALU_Control = 4'd0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] Result, Hi;
  logic         Zero, Branch_Taken, busy, done, error;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ALU_Control  (ALU_Control),
    .A            (A),
    .B            (B),
    .Result       (Result),
    .Hi           (Hi),
    .Zero         (Zero),
    .Branch_Taken (Branch_Taken),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]   code;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         zero;
    logic         br;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model of one operation; lat is cycles from launch to done.
  task automatic model(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                       output exp_t e, output int lat);
    logic [2*W-1:0] prod;
    e.code = code; e.res = '0; e.hi = '0; e.br = 1'b0; e.err = 1'b0; e.cyc = 0;
    lat = 1;
    case (code)
      4'h0: begin
        if (!MULDIV) e.err = 1'b1;
        else if (b == '0) begin
          e.err = 1'b1; e.res = '1; e.hi = a;
        end else begin
          e.res = a / b; e.hi = a % b; lat = W + 1;
        end
      end
      4'h1: begin
        if (!MULDIV) e.err = 1'b1;
        else begin
          prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
          e.res = prod[W-1:0]; e.hi = prod[2*W-1:W]; lat = W + 1;
        end
      end
      4'h2: e.res = a - b;
      4'h3: e.res = a + b;
      4'h4: e.res = a | b;
      4'h5: e.res = a & b;
      4'h6: begin e.res = a - b; e.br = (a != b); end
      4'h7: begin e.res = a - b; e.br = ($signed(a) > $signed(b)); end
      4'h8: begin e.res = a - b; e.br = ($signed(a) < $signed(b)); end
      default: e.err = 1'b1;
    endcase
    e.zero = (e.res == '0);
  endtask

  // Drive start for one cycle (call at a negedge), then scramble the inputs.
  task automatic issue(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   lat;
    model(code, a, b, e, lat);
    e.cyc = cyc + lat;
    sb.push_back(e);
    start = 1'b1; ALU_Control = code; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    ALU_Control = 4'($urandom);
    A = W'($urandom);
    B = W'($urandom);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_result"}, Result, 0);
    check({tag, "_hi"}, Hi, 0);
    check({tag, "_zero"}, Zero, 1);
    check({tag, "_branch"}, Branch_Taken, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    check("drain_timeout", sb.size(), 0);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        e = sb.pop_front();
        $display("txn code=%h Result=%h Hi=%h Zero=%b Br=%b err=%b cyc=%0d",
                 e.code, Result, Hi, Zero, Branch_Taken, error, cyc);
        check("done_cycle", cyc, e.cyc);
        check("result", Result, e.res);
        check("hi", Hi, e.hi);
        check("zero", Zero, e.zero);
        check("branch", Branch_Taken, e.br);
        check("error", error, e.err);
        check("busy_at_done", busy, 0);
      end
    end
  end

  int n0;

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single-cycle ops, issued back to back.
    issue(4'h3, 32'd5, 32'd7);
    issue(4'h2, 32'd3, 32'd3);
    issue(4'h3, 32'hFFFF_FFFF, 32'd1);
    issue(4'h4, 32'hF0F0_0000, 32'h0000_0F0F);
    issue(4'h5, 32'hFF00_FF00, 32'h0FF0_0FF0);
    issue(4'h7, 32'hFFFF_FFFF, 32'd1);
    issue(4'h8, 32'hFFFF_FFFF, 32'd1);
    issue(4'h6, 32'd9, 32'd9);
    issue(4'h6, 32'd9, 32'd4);
    issue(4'h7, 32'd10, 32'hFFFF_FFF0);
    issue(4'hA, 32'd1, 32'd2);
    issue(4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();

    // Multiply with a start attempted while busy, then divide on the done cycle.
    n0 = cyc;
    issue(4'h1, 32'hFFFF_FFFF, 32'd2);
    check("busy_first", busy, MULDIV);
    if (MULDIV) begin
      start = 1'b1; ALU_Control = 4'h3; A = 32'd1; B = 32'd1;
      @(negedge clk);
      start = 1'b0;
    end
    while (cyc < n0 + W) @(negedge clk);
    check("busy_last", busy, MULDIV);
    for (int k = 0; k < 100 && !done; k++) @(negedge clk);
    issue(4'h0, 32'd100, 32'd7);
    drain();
    issue(4'h0, 32'd100, 32'd0);
    issue(4'h0, 32'hFFFF_FFFF, 32'h0001_0000);
    drain();

    // Reset in the middle of a multiply: no done, reset values, then recover.
    n0 = cyc;
    issue(4'h1, 32'h1234_5678, 32'h9ABC_DEF0);
    while (cyc < n0 + 10) @(negedge clk);
    sb.delete();
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midreset");
    reset = 1'b0;
    repeat (W + 8) @(negedge clk);
    check("midreset_busy", busy, 0);
    issue(4'h3, 32'd20, 32'd22);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
